// File: rtl/cas_tape_player.sv
// CAS cassette-image player: captures a downloaded image into a byte buffer and replays it
// as a TRS-80 pulse-encoded tape signal (clock pulse each cell, data pulse mid-cell for a 1).
module cas_tape_player #(
  parameter int unsigned CLK_HZ  = 42000000,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned AUDIO_W = 9
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               dn_go,
  input  logic               dn_wr,
  input  logic [ADDR_W-1:0]  dn_addr,
  input  logic [7:0]         dn_data,
  input  logic               play,
  input  logic               rewind,
  input  logic [1:0]         mode,
  output logic               tape_out,
  output logic [AUDIO_W-1:0] tape_audio,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  pos,
  output logic [ADDR_W-1:0]  len
);

  localparam int unsigned Cell0 = CLK_HZ / 500;
  localparam int unsigned Cell1 = CLK_HZ / 1500;
  localparam int unsigned Cell2 = CLK_HZ / 250;
  localparam int unsigned CntW  = $clog2(Cell2 + 1);

  localparam logic [AUDIO_W-1:0] AudLo = {2'b01, {(AUDIO_W-2){1'b0}}};
  localparam logic [AUDIO_W-1:0] AudHi = {2'b11, {(AUDIO_W-2){1'b0}}};

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StCell, StPause} state_e;

  function automatic logic [CntW-1:0] cell_len(input logic [1:0] m);
    case (m)
      2'd1:    cell_len = CntW'(Cell1);
      2'd2:    cell_len = CntW'(Cell2);
      default: cell_len = CntW'(Cell0);
    endcase
  endfunction

  function automatic logic [CntW-1:0] pulse_w(input logic [1:0] m);
    logic [CntW-1:0] w;
    w = cell_len(m) >> 4;
    pulse_w = (w == '0) ? CntW'(1) : w;
  endfunction

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rd_data;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              done_q, done_d;
  logic              dn_go_q;
  logic              tape_q;
  logic [AUDIO_W-1:0] audio_q;

  logic [ADDR_W-1:0] wr_len;
  logic [ADDR_W-1:0] pos_inc;
  logic [CntW-1:0]   cell_d, pw_d, half_d;
  logic              pulse_d;

  // All-ones address would wrap to zero; clamp instead.
  assign wr_len  = (&dn_addr) ? dn_addr : dn_addr + ADDR_W'(1);
  assign pos_inc = pos_q + ADDR_W'(1);

  always_ff @(posedge clk_sys) begin
    if (dn_go && dn_wr) mem[dn_addr] <= dn_data;
    rd_data <= mem[pos_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    len_d   = len_q;
    done_d  = done_q;

    if (dn_go && !dn_go_q) begin
      len_d  = '0;
      pos_d  = '0;
      done_d = 1'b0;
    end
    if (dn_go && dn_wr && (wr_len > len_d)) len_d = wr_len;

    if (dn_go) begin
      state_d = StIdle;
      cnt_d   = '0;
      bit_d   = 3'd7;
    end else if (rewind) begin
      state_d = StIdle;
      cnt_d   = '0;
      bit_d   = 3'd7;
      pos_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (play && !done_q) begin
            if (len_q == '0)        done_d  = 1'b1;
            else if (pos_q < len_q) state_d = StFetch;
          end
        end
        StFetch: state_d = StLoad;
        StLoad: begin
          shreg_d = rd_data;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = StCell;
        end
        StCell: begin
          if (cnt_q == cell_len(mode_q) - CntW'(1)) begin
            cnt_d = '0;
            if (bit_q == 3'd0) begin
              bit_d = 3'd7;
              pos_d = pos_inc;
              if (pos_inc == len_q) begin
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                state_d = play ? StFetch : StPause;
              end
            end else begin
              bit_d = bit_q - 3'd1;
              if (play) mode_d = mode;
              state_d = play ? StCell : StPause;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPause: begin
          // Bit index 7 here means the next byte has not been fetched yet.
          if (play) begin
            if (bit_q == 3'd7) begin
              state_d = StFetch;
            end else begin
              state_d = StCell;
              cnt_d   = '0;
              mode_d  = mode;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    cell_d  = cell_len(mode_d);
    pw_d    = pulse_w(mode_d);
    half_d  = cell_d >> 1;
    pulse_d = (state_d == StCell) &&
              ((cnt_d < pw_d) ||
               (shreg_d[bit_d] && (cnt_d >= half_d) && (cnt_d < half_d + pw_d)));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd7;
      shreg_q <= '0;
      mode_q  <= '0;
      pos_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      dn_go_q <= 1'b0;
      tape_q  <= 1'b0;
      audio_q <= AudLo;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      done_q  <= done_d;
      dn_go_q <= dn_go;
      tape_q  <= pulse_d;
      audio_q <= pulse_d ? AudHi : AudLo;
    end
  end

  assign tape_out   = tape_q;
  assign tape_audio = audio_q;
  assign busy       = (state_q == StCell);
  assign done       = done_q;
  assign pos        = pos_q;
  assign len        = len_q;

endmodule

// File: tb/tb_cas_tape_player.sv
// Bench for cas_tape_player: a reference model predicts every tape pulse (start cycle, width);
// a monitor measures the pulses the DUT emits and checks them against the queue.
module tb_cas_tape_player;

  localparam int CLK_HZ  = 16000;
  localparam int ADDR_W  = 4;
  localparam int AUDIO_W = 9;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              dn_go, dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              play, rewind;
  logic [1:0]        mode;
  logic              tape_out;
  logic [AUDIO_W-1:0] tape_audio;
  logic              busy, done;
  logic [ADDR_W-1:0] pos, len;

  cas_tape_player #(.CLK_HZ(CLK_HZ), .ADDR_W(ADDR_W), .AUDIO_W(AUDIO_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr),
    .dn_data(dn_data), .play(play), .rewind(rewind), .mode(mode), .tape_out(tape_out),
    .tape_audio(tape_audio), .busy(busy), .done(done), .pos(pos), .len(len)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {int s; int w;} pulse_t;
  pulse_t exp_q[$];
  logic [7:0] img [16];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int start_c = 0;
  logic prev_out = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp,
               cyc);
    end
  endtask

  function automatic int cell_of(input int md);
    case (md)
      1:       return CLK_HZ / 1500;
      2:       return CLK_HZ / 250;
      default: return CLK_HZ / 500;
    endcase
  endfunction

  task automatic push_pulse(input int s, input int w);
    pulse_t p;
    p.s = s;
    p.w = w;
    exp_q.push_back(p);
  endtask

  // Predict pulses for ncells bit cells starting at (byte j, bit b) at cycle t.
  // A new byte costs two extra cycles (fetch + load). t returns the end of the last cell.
  task automatic model_cells(input int j0, input int b0, input int ncells, input int md,
                             inout int t);
    int cl, pw, j, b;
    cl = cell_of(md);
    pw = (cl / 16 > 0) ? cl / 16 : 1;
    j  = j0;
    b  = b0;
    for (int n = 0; n < ncells; n++) begin
      push_pulse(t, pw);
      if (img[j][b]) push_pulse(t + cl / 2, pw);
      t += cl;
      if (b == 0) begin
        b = 7;
        j++;
        if (n != ncells - 1) t += 2;
      end else begin
        b--;
      end
    end
  endtask

  // Monitor: measure each tape_out pulse and score it against the model.
  always @(negedge clk_sys) begin
    pulse_t p;
    if (tape_out && !prev_out) begin
      start_c = cyc;
      check("audio_hi", int'(tape_audio), 'h180);
    end
    if (!tape_out && prev_out) begin
      check("audio_lo", int'(tape_audio), 'h080);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d width %0d, want none", start_c,
                 cyc - start_c);
      end else begin
        p = exp_q.pop_front();
        check("pulse_start", start_c, p.s);
        check("pulse_width", cyc - start_c, p.w);
      end
    end
    prev_out = tape_out;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_sys);
  endtask

  task automatic load_image(input int n);
    for (int i = 0; i < n; i++) begin
      dn_go   = 1'b1;
      dn_wr   = 1'b1;
      dn_addr = 4'(i);
      dn_data = img[i];
      @(negedge clk_sys);
    end
    dn_wr = 1'b0;
    dn_go = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_done(input int exp_c, input int exp_pos, input string nm);
    int lim;
    lim = 6000;
    while (!done && lim > 0) begin
      @(negedge clk_sys);
      lim--;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got done=0, want done=1 by cycle %0d", nm, exp_c);
    end else begin
      check({nm, "_done_cyc"}, cyc, exp_c);
      check({nm, "_pos"}, int'(pos), exp_pos);
      check({nm, "_busy_end"}, int'(busy), 0);
    end
    check({nm, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_image(input int n, input int md, input string nm);
    int t;
    load_image(n);
    mode = 2'(md);
    check({nm, "_len"}, int'(len), n);
    play = 1'b1;
    t = cyc + 3;
    model_cells(0, 7, 8 * n, md, t);
    wait_done(t, n, nm);
    play = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    int t, s, k;
    reset_n = 1'b0;
    dn_go = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    play = 1'b0; rewind = 1'b0; mode = 2'd0;
    repeat (2) @(negedge clk_sys);
    check("rst_tape", int'(tape_out), 0);
    check("rst_audio", int'(tape_audio), 'h080);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pos", int'(pos), 0);
    check("rst_len", int'(len), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Length saturation at the all-ones address; a lower address keeps len.
    dn_go = 1'b1; dn_wr = 1'b1; dn_addr = 4'hF; dn_data = 8'h11;
    @(negedge clk_sys);
    dn_addr = 4'h3;
    @(negedge clk_sys);
    dn_go = 1'b0; dn_wr = 1'b0;
    @(negedge clk_sys);
    check("len_sat", int'(len), 15);

    img[0] = 8'hA5; img[1] = 8'h00; img[2] = 8'hFF;
    run_image(3, 0, "basic");

    img[0] = 8'h80;
    run_image(1, 1, "mode1");
    run_image(1, 2, "mode2");
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      run_image(n, $urandom_range(0, 3), "rand");
    end

    // Pause at c=8 of bit 5 of byte 0, then resume at bit 4.
    img[0] = 8'h2C; img[1] = 8'($urandom);
    load_image(2);
    mode = 2'd0;
    play = 1'b1;
    t = cyc + 3;
    model_cells(0, 7, 3, 0, t);
    s = t - 32;
    wait_cyc(s + 8);
    check("pause_busy", int'(busy), 1);
    play = 1'b0;
    wait_cyc(s + 60);
    check("pause_pos", int'(pos), 0);
    check("pause_busy_off", int'(busy), 0);
    check("pause_tape", int'(tape_out), 0);
    play = 1'b1;
    t = cyc + 1;
    model_cells(0, 4, 13, 0, t);
    wait_done(t, 2, "pause");
    play = 1'b0;
    @(negedge clk_sys);

    // Rewind with play held, mid byte 1 (bit 4, c=3).
    img[0] = 8'($urandom); img[1] = 8'($urandom);
    load_image(2);
    mode = 2'd1;
    play = 1'b1;
    t = cyc + 3;
    model_cells(0, 7, 11, 1, t);
    push_pulse(t, 1);
    wait_cyc(t + 3);
    rewind = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("rew_pos", int'(pos), 0);
    check("rew_done", int'(done), 0);
    check("rew_busy", int'(busy), 0);
    rewind = 1'b0;
    t = cyc + 3;
    model_cells(0, 7, 16, 1, t);
    wait_done(t, 2, "rewind");
    play = 1'b0;
    @(negedge clk_sys);

    // Empty image: play only raises done.
    dn_go = 1'b1;
    @(negedge clk_sys);
    dn_go = 1'b0;
    @(negedge clk_sys);
    check("empty_len", int'(len), 0);
    play = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("empty_done", int'(done), 1);
    repeat (10) @(negedge clk_sys);
    play = 1'b0;
    @(negedge clk_sys);

    // dn_go raised at the clock pulse of bit 5 aborts playback.
    img[0] = 8'($urandom); img[1] = 8'($urandom);
    load_image(2);
    mode = 2'd0;
    play = 1'b1;
    t = cyc + 3;
    model_cells(0, 7, 2, 0, t);
    push_pulse(t, 1);
    wait_cyc(t);
    check("abort_pre", int'(tape_out), 1);
    dn_go = 1'b1;
    @(negedge clk_sys);
    check("abort_tape", int'(tape_out), 0);
    check("abort_len", int'(len), 0);
    check("abort_pos", int'(pos), 0);
    check("abort_busy", int'(busy), 0);
    play = 1'b0;
    dn_go = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("abort_drain", exp_q.size(), 0);

    // Reset during a 0x180 pulse; buffer must survive it.
    for (int i = 0; i < 3; i++) img[i] = 8'($urandom);
    load_image(3);
    mode = 2'd0;
    play = 1'b1;
    t = cyc + 3;
    push_pulse(t, 1);
    wait_cyc(t);
    check("rstmid_audio_pre", int'(tape_audio), 'h180);
    reset_n = 1'b0;
    play = 1'b0;
    @(negedge clk_sys);
    check("rstmid_audio", int'(tape_audio), 'h080);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_len", int'(len), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    dn_go = 1'b1; dn_wr = 1'b1; dn_addr = 4'd2; dn_data = img[2];
    @(negedge clk_sys);
    dn_go = 1'b0; dn_wr = 1'b0;
    @(negedge clk_sys);
    check("retain_len", int'(len), 3);
    play = 1'b1;
    k = cyc + 3;
    t = k;
    model_cells(0, 7, 24, 0, t);
    wait_done(t, 3, "retain");
    play = 1'b0;
    @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/cas_tape_player.md
Name: cas_tape_player

Overview:
- Parametrised cassette-image player for the TRS-80 core.
- Captures a CAS image streamed over the HPS ioctl download port into an internal byte buffer.
- Replays the image as a TRS-80 pulse-encoded tape signal with selectable baud rate, pause/resume and rewind.
- Sits beside the ht1080z core. Feeds its cassette input (tape_out) and the audio mix (tape_audio); exposes position and length for OSD/LED use.

Parameters:
- CLK_HZ, 42000000, clk_sys frequency in Hz; all timing is derived from it at elaboration.
- ADDR_W, 16, buffer address width; depth = 2^ADDR_W bytes.
- AUDIO_W, 9, width of tape_audio; must be >= 3.

Ports:
- clk_sys  in  1  system clock; everything is synchronous to its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dn_go  in  1  download active; writes are accepted only while high.
- dn_wr  in  1  one-cycle write strobe.
- dn_addr  in  ADDR_W  byte address of the write.
- dn_data  in  8  byte to write.
- play  in  1  level; high = run, low = pause.
- rewind  in  1  level; return to start of image.
- mode  in  2  baud select: 0=500, 1=1500, 2=250, 3=500.
- tape_out  out  1  pulse-encoded tape bit.
- tape_audio  out  AUDIO_W  unsigned audio of tape_out.
- busy  out  1  high while a bit cell is in progress.
- done  out  1  high when the whole image has been played.
- pos  out  ADDR_W  index of the current byte.
- len  out  ADDR_W  image length in bytes.

Behaviour:
- Reset (reset_n=0, sampled on a clock edge):
  - tape_out=0, tape_audio={2'b01,0...}, busy=0, done=0, pos=0, len=0.
  - State = IDLE, bit index=7.
  - Buffer contents are not cleared.
- Download:
  - A write happens when dn_go && dn_wr; buf[dn_addr] <= dn_data.
  - len <= max(len, dn_addr+1). An address of all-ones saturates len at 2^ADDR_W-1.
  - On the dn_go rising edge: len<=0, pos<=0, done<=0, state=IDLE.
  - While dn_go=1, the FSM is held in IDLE and tape_out=0. This abort applies even mid-cell.
- Buffer read: synchronous, 1-cycle latency.
- Timing per bit cell:
  - CELL = CLK_HZ/baud (integer division).
  - PW = max(1, CELL/16).
  - mode is sampled only at cell start.
- FSM states:
  - IDLE → FETCH when play && !rewind && !dn_go && pos<len && !done.
  - IDLE with play=1, pos>=len, len=0 → done<=1; no pulses are emitted.
  - FETCH: issue the read of buf[pos]; goes to LOAD.
  - LOAD: latch the byte into the shift register; goes to CELL.
  - CELL: cycle counter c runs 0..CELL-1.
    - tape_out=1 for c in [0,PW) (clock pulse).
    - tape_out=1 for c in [CELL/2, CELL/2+PW) if the current bit=1 (data pulse).
    - tape_out=0 at all other times.
    - busy=1.
  - CELL end:
    - Bit index decrements; bits are sent MSB first.
    - After bit 0: pos<=pos+1 and bit index=7.
    - If pos+1==len: done<=1, go to IDLE.
    - Else if play=1: go to FETCH for a new byte, or start the next CELL directly for the next bit.
    - Else (play=0): go to PAUSE.
  - PAUSE: holds pos and bit index; tape_out=0. Goes to CELL (or FETCH at a byte boundary) when play=1.
- play falling mid-cell: the current cell completes, then the FSM pauses.
- rewind=1: on the next cycle pos<=0, bit index=7, done<=0, state=IDLE, tape_out=0. rewind has priority over play and beats the cell-end update in the same cycle.
- Latency: play rising in IDLE puts tape_out=1 at the third clock edge after play is sampled (FETCH, LOAD, then CELL c=0).
- tape_audio: tape_out ? {2'b11,0...} : {2'b01,0...}. For AUDIO_W=9 this is 0x180 / 0x080. Registered, tracking tape_out with the same timing.
- A write to an address below pos during playback takes effect on the next fetch of that address.

Test Plan:
- Bench params: CLK_HZ=16000, ADDR_W=4. Mode 0 gives CELL=32, PW=2, data pulse at c=16.
- Download A5,00,FF at addrs 0..2, then play mode 0 → len=3. A5 bit7 cell: pulses at c=0..1 and c=16..17. The 00 cells have the clock pulse only. done=1 exactly 24 cells after the first pulse; pos=3.
- Mode 1 (CELL=10, PW=1) and mode 2 (CELL=64, PW=4) on byte 80 → clock pulse every 10/64 cycles. Data pulse at c=5 (mode 1) or c=32..35 (mode 2) for bit7 only.
- Drop play at c=8 of bit 5 of byte 0 → that cell completes, tape_out stays 0, pos=0. Raise play → next cell is bit 4.
- Assert rewind and play together mid-byte 1 → pos=0, done=0, no pulse until rewind drops. Then playback restarts from byte 0 bit 7.
- Raise play with len=0 → done=1 within 2 cycles and tape_out never goes high. Raise dn_go mid-cell → tape_out=0 next cycle, len=0, pos=0.
- Pull reset_n low mid-cell at 0x180 output → next edge: tape_audio=0x080, busy=0. Buffer bytes are retained and replay after play is reasserted.
